// File: rtl/pkg_framer_pkg.sv
// Shared definitions for the packet framer: default parameters, FSM state
// encoding and a small helper for sizing the idle-gap counter.
package pkg_framer_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_MAX_LEN = 256;
    localparam int DEF_GAP_LEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_EOF     = 3'd2,
        ST_DROP    = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // The gap counter must hold GAP_LEN; keep it at least one bit wide so a
    // zero-length gap still yields a legal declaration.
    function automatic int gap_cnt_width(input int gap_len);
        return (gap_len < 1) ? 1 : $clog2(gap_len + 1);
    endfunction

endpackage

// File: rtl/pkg_framer_if.sv
// Payload-in / framed-out stream bundle. The framer sits on the slave
// modport; the sample source and downstream sink use the master modport.
interface pkg_framer_if
    import pkg_framer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic signed [2*WIDTH-1:0] s_data_i;
    logic                      s_valid_i;
    logic                      s_last_i;
    logic                      s_ready_o;
    logic signed [2*WIDTH-1:0] m_data_o;
    logic                      m_valid_o;
    logic                      m_ready_i;

    modport slave (
        input  s_data_i, s_valid_i, s_last_i, m_ready_i,
        output s_ready_o, m_data_o, m_valid_o
    );

    modport master (
        output s_data_i, s_valid_i, s_last_i, m_ready_i,
        input  s_ready_o, m_data_o, m_valid_o
    );
endinterface

// File: rtl/pkg_clip.sv
// Marker-collision clipper: nudges a payload sample that equals the start or
// stop marker one step toward zero so the receiver never sees a false marker.
module pkg_clip
    import pkg_framer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [2*WIDTH-1:0] data_i,
    output logic signed [2*WIDTH-1:0] data_o,
    output logic                      clipped_o
);
    localparam int SW = 2 * WIDTH;
    localparam logic [SW-1:0] MARK_START = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] MARK_STOP  = {1'b1, {(SW-1){1'b0}}};

    // Replace marker values with their nearest non-marker neighbour.
    always_comb begin
        data_o    = data_i;
        clipped_o = 1'b0;
        if (data_i == MARK_START) begin
            data_o    = MARK_START - SW'(1);
            clipped_o = 1'b1;
        end else if (data_i == MARK_STOP) begin
            data_o    = MARK_STOP + SW'(1);
            clipped_o = 1'b1;
        end
    end
endmodule

// File: rtl/pkg_framer.sv
// Transmit-side packet framer: wraps payload samples between a start marker
// and a stop marker, then enforces an idle gap. Over-long packets are cut at
// MAX_LEN and their remaining samples are swallowed.
module pkg_framer
    import pkg_framer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int GAP_LEN = DEF_GAP_LEN
) (
    input  logic         clk,
    input  logic         rst,
    pkg_framer_if.slave  bus,
    output logic         busy_o,
    output logic         clip_o,
    output logic         trunc_o
);
    localparam int SW = 2 * WIDTH;
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int GW = gap_cnt_width(GAP_LEN);
    localparam logic [SW-1:0] MARK_START = {1'b0, {(SW-1){1'b1}}};
    localparam logic [SW-1:0] MARK_STOP  = {1'b1, {(SW-1){1'b0}}};

    state_t          state;
    logic [SW-1:0]   m_data_q;
    logic            m_valid_q;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap_cnt;
    logic            trunc_flag;
    logic            out_free;
    logic            s_ready;
    logic            accept;
    logic            at_limit;
    logic [SW-1:0]   clip_data;
    logic            clipped;

    pkg_clip #(.WIDTH(WIDTH)) u_clip (
        .data_i   (bus.s_data_i),
        .data_o   (clip_data),
        .clipped_o(clipped)
    );

    assign out_free      = !m_valid_q || bus.m_ready_i;
    assign accept        = bus.s_valid_i && s_ready;
    assign at_limit      = (cnt == CW'(MAX_LEN - 1));
    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_valid_o = m_valid_q;
    assign busy_o        = (state != ST_IDLE);
    assign clip_o        = accept && (state == ST_PAYLOAD) && clipped;
    assign trunc_o       = accept && (state == ST_PAYLOAD) && !bus.s_last_i && at_limit;

    // Payload is taken only while the output register can accept it; in DROP
    // samples are swallowed unconditionally.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_PAYLOAD: s_ready = out_free;
            ST_DROP:    s_ready = 1'b1;
            default:    s_ready = 1'b0;
        endcase
    end

    // Framing FSM driving the registered output stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            cnt        <= '0;
            gap_cnt    <= '0;
            trunc_flag <= 1'b0;
        end else begin
            if (out_free) begin
                m_valid_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.s_valid_i && out_free) begin
                        m_data_q  <= MARK_START;
                        m_valid_q <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        m_data_q  <= clip_data;
                        m_valid_q <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        if (bus.s_last_i) begin
                            state <= ST_EOF;
                        end else if (at_limit) begin
                            trunc_flag <= 1'b1;
                            state      <= ST_EOF;
                        end
                    end
                end
                ST_EOF: begin
                    if (out_free) begin
                        m_data_q   <= MARK_STOP;
                        m_valid_q  <= 1'b1;
                        trunc_flag <= 1'b0;
                        if (trunc_flag) begin
                            state <= ST_DROP;
                        end else if (GAP_LEN == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= GW'(GAP_LEN);
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.s_valid_i && bus.s_last_i) begin
                        if (GAP_LEN == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= GW'(GAP_LEN);
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= GW'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
